// File: rtl/edge_detect_pkg.sv
// Shared types for the multi-channel edge detector: channel modes, FSM states
// and the stability-counter width helper.
package edge_detect_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_t;

    typedef enum logic {
        S_LOW  = 1'b0,
        S_HIGH = 1'b1
    } state_t;

    // A one-sample filter still needs a 1-bit counter to keep the logic uniform.
    function automatic int cnt_width(input int stable_cycles);
        return (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
    endfunction

endpackage

// File: rtl/multi_channel_edge_detector_if.sv
// Channel bus of the edge detector: raw inputs and controls in, filtered
// levels, pulses and sticky flags out.
interface multi_channel_edge_detector_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   in;
    logic [2*CHANNELS-1:0] mode;
    logic [CHANNELS-1:0]   event_clr;
    logic [CHANNELS-1:0]   level;
    logic [CHANNELS-1:0]   out;
    logic [CHANNELS-1:0]   event_flag;
    logic                  any_event;

    modport master (
        output in, mode, event_clr,
        input  level, out, event_flag, any_event
    );

    modport slave (
        input  in, mode, event_clr,
        output level, out, event_flag, any_event
    );
endinterface

// File: rtl/edge_detect_channel.sv
// One channel: glitch-filter FSM, stretched edge pulse and sticky event flag.
// flag_d_o exposes the next flag so the top can register any_event in step.
module edge_detect_channel
    import edge_detect_pkg::*;
#(
    parameter int STABLE_CYCLES = 1,
    parameter int PULSE_LEN     = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_i,
    input  mode_t mode_i,
    input  logic  clr_i,
    output logic  level_o,
    output logic  out_o,
    output logic  flag_o,
    output logic  flag_d_o
);
    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic            flag_q, flag_d;
    logic            accept;
    logic            qual;

    // Count samples that disagree with the current level; any agreeing sample restarts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (in_i != (state_q == S_HIGH)) begin
            if (cnt_q == CNT_MAX) begin
                state_d = (state_q == S_HIGH) ? S_LOW : S_HIGH;
                cnt_d   = '0;
                accept  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_comb begin
        qual = 1'b0;
        if (accept) begin
            if (state_q == S_LOW) qual = (mode_i == MODE_RISE) || (mode_i == MODE_BOTH);
            else                  qual = (mode_i == MODE_FALL) || (mode_i == MODE_BOTH);
        end
    end

    // Retrigger reloads rather than queues; set beats clear on the flag.
    always_comb begin
        pcnt_d = pcnt_q;
        if (qual)              pcnt_d = PULSE_LOAD;
        else if (pcnt_q != '0) pcnt_d = pcnt_q - 1'b1;
        flag_d = flag_q;
        if (qual)       flag_d = 1'b1;
        else if (clr_i) flag_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            flag_q  <= flag_d;
        end
    end

    assign level_o  = (state_q == S_HIGH);
    assign out_o    = (pcnt_q != '0);
    assign flag_o   = flag_q;
    assign flag_d_o = flag_d;

endmodule

// File: rtl/multi_channel_edge_detector.sv
// Array of independent glitch-filtered edge detectors; the top only slices the
// per-channel mode field and registers the OR of all event flags.
module multi_channel_edge_detector
    import edge_detect_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 1,
    parameter int PULSE_LEN     = 1
) (
    input logic                         clk,
    input logic                         rst,
    multi_channel_edge_detector_if.slave bus
);
    logic [CHANNELS-1:0] flag_d;
    logic                any_event_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        edge_detect_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .PULSE_LEN     (PULSE_LEN)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .in_i     (bus.in[g]),
            .mode_i   (mode_t'(bus.mode[2*g +: 2])),
            .clr_i    (bus.event_clr[g]),
            .level_o  (bus.level[g]),
            .out_o    (bus.out[g]),
            .flag_o   (bus.event_flag[g]),
            .flag_d_o (flag_d[g])
        );
    end

    // Built from next-state flags so it moves in the same cycle as event_flag.
    always_ff @(posedge clk) begin
        if (rst) any_event_q <= 1'b0;
        else     any_event_q <= |flag_d;
    end

    assign bus.any_event = any_event_q;

endmodule
